// File: rtl/fetch_pc_ctrl.sv
// Purpose     : program counter and fetch-redirect controller for the 3-stage pipeline.
// Latency     : fetch address issued combinationally from pc_q; redirect takes effect at the next edge, flush_o in the same cycle.
// Backpressure: if_ready_i low holds pc_q with if_valid_o still asserted; stall_i drops the request and holds the PC.
//
// Ports:
//   clk, rst           clock and asynchronous active-high reset
//   stall_i            hazard stall: holds the PC and suppresses the fetch request
//   br_valid_i         execute stage presents a resolved branch/jump
//   branch_taken       resolution result, qualified by br_valid_i
//   br_target          redirect target (low two bits ignored)
//   if_ready_i         instruction memory accepts the request
//   if_valid_o, pc_o   fetch request and address
//   flush_o            kill the instruction held in the fetch/decode register
//   br_taken_cnt_o     taken-branch count   (BRANCH_STATS_EN builds only, else 0)
//   br_total_cnt_o     resolved-branch count (BRANCH_STATS_EN builds only, else 0)
//
// Optional feature macro: BRANCH_STATS_EN enables the two branch statistics counters.

module fetch_pc_ctrl #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int unsigned FLUSH_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        br_valid_i,
    input  logic        branch_taken,
    input  logic [31:0] br_target,
    input  logic        if_ready_i,
    output logic        if_valid_o,
    output logic [31:0] pc_o,
    output logic        flush_o,
    output logic [31:0] br_taken_cnt_o,
    output logic [31:0] br_total_cnt_o
);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    // Bubble counter load value; only four bits are meaningful (0..15).
    localparam logic [3:0] BUBBLE_LOAD = 4'(FLUSH_CYCLES);

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [3:0]  bubble_q, bubble_d;

    logic        redirect;
    logic        fetch_req;
    logic        fire;
    logic        resolved;

    // A resolution is only acted upon once the boot cycle is over.
    assign resolved  = br_valid_i & (state_q != ST_BOOT);
    assign redirect  = resolved & branch_taken;
    assign fetch_req = (state_q == ST_RUN) & ~stall_i;
    assign fire      = fetch_req & if_ready_i;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        bubble_d = bubble_q;

        case (state_q)
            ST_BOOT: begin
                state_d = ST_RUN;
            end

            ST_RUN: begin
                if (redirect) begin
                    // Redirect outranks both fire and stall: the accepted
                    // wrong-path fetch does not advance the PC.
                    pc_d = br_target & 32'hFFFF_FFFC;
                    if (FLUSH_CYCLES == 0) begin
                        state_d  = ST_RUN;
                        bubble_d = 4'd0;
                    end else begin
                        state_d  = ST_FLUSH;
                        bubble_d = BUBBLE_LOAD;
                    end
                end else if (fire) begin
                    pc_d = pc_q + 32'd4;
                end
            end

            ST_FLUSH: begin
                if (redirect) begin
                    // A fresh redirect inside the bubble restarts the window.
                    pc_d     = br_target & 32'hFFFF_FFFC;
                    bubble_d = BUBBLE_LOAD;
                end else begin
                    // stall_i deliberately plays no part in the countdown.
                    bubble_d = (bubble_q == 4'd0) ? 4'd0 : bubble_q - 4'd1;
                    if (bubble_q <= 4'd1) begin
                        state_d = ST_RUN;
                    end
                end
            end

            default: begin
                // Unused encoding: recover through the boot cycle.
                state_d  = ST_BOOT;
                bubble_d = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_BOOT;
            pc_q     <= RESET_PC;
            bubble_q <= 4'd0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            bubble_q <= bubble_d;
        end
    end

    assign if_valid_o = fetch_req;
    assign pc_o       = pc_q;
    assign flush_o    = redirect | (state_q == ST_FLUSH);

`ifdef BRANCH_STATS_EN
    logic [31:0] br_total_cnt_q, br_total_cnt_d;
    logic [31:0] br_taken_cnt_q, br_taken_cnt_d;

    always_comb begin
        br_total_cnt_d = br_total_cnt_q;
        br_taken_cnt_d = br_taken_cnt_q;
        if (resolved) begin
            br_total_cnt_d = br_total_cnt_q + 32'd1;
        end
        if (redirect) begin
            br_taken_cnt_d = br_taken_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            br_total_cnt_q <= 32'd0;
            br_taken_cnt_q <= 32'd0;
        end else begin
            br_total_cnt_q <= br_total_cnt_d;
            br_taken_cnt_q <= br_taken_cnt_d;
        end
    end

    assign br_total_cnt_o = br_total_cnt_q;
    assign br_taken_cnt_o = br_taken_cnt_q;
`else
    assign br_total_cnt_o = 32'h0;
    assign br_taken_cnt_o = 32'h0;
`endif

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Purpose     : self-checking bench for fetch_pc_ctrl, two instances with different parameters on shared stimulus.
// Latency     : expectations pushed one record per cycle, popped by the monitor on the falling edge.
// Backpressure: if_ready_i is driven low in directed and random phases to exercise request holding.

module tb_fetch_pc_ctrl;

    typedef struct packed {
        logic        vld;
        logic        flush;
        logic [31:0] pc;
        logic [31:0] tot;
        logic [31:0] tak;
    } exp_t;

    localparam logic [31:0] RPC0 = 32'h0000_0000;
    localparam logic [31:0] RPC1 = 32'hFFFF_FFFC;
    localparam int          FC0  = 1;
    localparam int          FC1  = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_i;
    logic        br_valid_i;
    logic        branch_taken;
    logic [31:0] br_target;
    logic        if_ready_i;

    logic        v0, f0, v1, f1;
    logic [31:0] p0, tk0, tt0, p1, tk1, tt1;

    int n_checks = 0;
    int n_fail   = 0;

    exp_t q0[$];
    exp_t q1[$];

    // Reference model state: boot flag, remaining bubble cycles, PC, counts.
    logic [31:0] m_pc  [2];
    logic        m_boot[2];
    int          m_bub [2];
    logic [31:0] m_tot [2];
    logic [31:0] m_tak [2];

    always #5 clk = ~clk;

    fetch_pc_ctrl #(.RESET_PC(RPC0), .FLUSH_CYCLES(FC0)) dut0 (
        .clk(clk), .rst(rst), .stall_i(stall_i), .br_valid_i(br_valid_i),
        .branch_taken(branch_taken), .br_target(br_target), .if_ready_i(if_ready_i),
        .if_valid_o(v0), .pc_o(p0), .flush_o(f0),
        .br_taken_cnt_o(tk0), .br_total_cnt_o(tt0)
    );

    fetch_pc_ctrl #(.RESET_PC(RPC1), .FLUSH_CYCLES(FC1)) dut1 (
        .clk(clk), .rst(rst), .stall_i(stall_i), .br_valid_i(br_valid_i),
        .branch_taken(branch_taken), .br_target(br_target), .if_ready_i(if_ready_i),
        .if_valid_o(v1), .pc_o(p1), .flush_o(f1),
        .br_taken_cnt_o(tk1), .br_total_cnt_o(tt1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected outputs for this cycle, then advance the model across the coming edge.
    task automatic model(input int i, output exp_t e);
        logic [31:0] rpc;
        int          fc;
        logic        in_flush, redir;
        rpc = (i == 0) ? RPC0 : RPC1;
        fc  = (i == 0) ? FC0  : FC1;
        e   = '0;
        if (rst) begin
            e.pc      = rpc;
            m_pc[i]   = rpc;
            m_boot[i] = 1'b1;
            m_bub[i]  = 0;
            m_tot[i]  = 0;
            m_tak[i]  = 0;
            return;
        end
`ifdef BRANCH_STATS_EN
        e.tot = m_tot[i];
        e.tak = m_tak[i];
`endif
        e.pc = m_pc[i];
        if (m_boot[i]) begin
            m_boot[i] = 1'b0;
            return;
        end
        in_flush = (m_bub[i] > 0);
        redir    = br_valid_i && branch_taken;
        e.vld    = !in_flush && !stall_i;
        e.flush  = redir || in_flush;
        if (br_valid_i) m_tot[i] = m_tot[i] + 1;
        if (redir)      m_tak[i] = m_tak[i] + 1;
        if (redir) begin
            m_pc[i]  = {br_target[31:2], 2'b00};
            m_bub[i] = fc;
        end else if (in_flush) begin
            m_bub[i] = m_bub[i] - 1;
        end else if (e.vld && if_ready_i) begin
            m_pc[i] = m_pc[i] + 32'd4;
        end
    endtask

    task automatic step(input logic r, input logic st, input logic bv, input logic bt,
                        input logic [31:0] tgt, input logic rdy);
        exp_t e;
        @(posedge clk);
        #1;
        rst          = r;
        stall_i      = st;
        br_valid_i   = bv;
        branch_taken = bt;
        br_target    = tgt;
        if_ready_i   = rdy;
        model(0, e); q0.push_back(e);
        model(1, e); q1.push_back(e);
    endtask

    task automatic cmp(input string tag, input exp_t e, input logic v, input logic f,
                       input logic [31:0] p, input logic [31:0] tt, input logic [31:0] tk);
        chk({tag, "_valid"}, {31'd0, v}, {31'd0, e.vld});
        chk({tag, "_flush"}, {31'd0, f}, {31'd0, e.flush});
        chk({tag, "_pc"}, p, e.pc);
        chk({tag, "_total"}, tt, e.tot);
        chk({tag, "_taken"}, tk, e.tak);
    endtask

    // Monitor: independent of the stimulus process, compares once per cycle.
    always @(negedge clk) begin
        exp_t e;
        if (q0.size() > 0) begin
            e = q0.pop_front();
            cmp("sb0", e, v0, f0, p0, tt0, tk0);
        end
        if (q1.size() > 0) begin
            e = q1.pop_front();
            cmp("sb1", e, v1, f1, p1, tt1, tk1);
        end
    end

    initial begin
        logic [31:0] exp_tot, exp_tak;
        rst = 1'b1; stall_i = 1'b0; br_valid_i = 1'b0; branch_taken = 1'b0;
        br_target = 32'h0; if_ready_i = 1'b0;
        for (int k = 0; k < 2; k++) begin
            m_pc[k] = 0; m_boot[k] = 1'b1; m_bub[k] = 0; m_tot[k] = 0; m_tak[k] = 0;
        end

        // Reset, boot cycle, sequential fetch and RESET_PC wrap.
        step(1, 0, 0, 0, 0, 1);
        #1 chk("reset_pc1", p1, 32'hFFFF_FFFC);
        chk("reset_valid0", {31'd0, v0}, 32'd0);
        step(1, 0, 0, 0, 0, 1);
        step(0, 0, 1, 1, 32'h0000_0080, 1);
        #1 chk("boot_valid0", {31'd0, v0}, 32'd0);
        chk("boot_flush0", {31'd0, f0}, 32'd0);
        step(0, 0, 0, 0, 0, 1);
        #1 chk("run_pc0_a", p0, 32'h0);
        chk("run_valid0", {31'd0, v0}, 32'd1);
        step(0, 0, 0, 0, 0, 1);
        #1 chk("run_pc0_b", p0, 32'h4);
        chk("wrap_pc1", p1, 32'h0);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        #1 chk("run_pc0_d", p0, 32'hC);

        // Redirect at pc 0x10 to an unaligned target.
        step(0, 0, 1, 1, 32'h0000_0103, 1);
        #1 chk("redir_pc0_before", p0, 32'h10);
        chk("redir_flush0", {31'd0, f0}, 32'd1);
        step(0, 0, 0, 0, 0, 1);
        #1 chk("bubble_flush0", {31'd0, f0}, 32'd1);
        chk("bubble_valid0", {31'd0, v0}, 32'd0);
        step(0, 0, 0, 0, 0, 1);
        #1 chk("resume_pc0", p0, 32'h100);
        chk("resume_valid0", {31'd0, v0}, 32'd1);
        chk("bubble3_flush1", {31'd0, f1}, 32'd1);

        // Second redirect: dut1 is still in its 3-cycle bubble and restarts it.
        step(0, 0, 1, 1, 32'h0000_0300, 1);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0);
        #1 chk("hold_pc0_a", p0, 32'h300);
        chk("restart_flush1", {31'd0, f1}, 32'd1);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        #1 chk("hold_pc0_c", p0, 32'h300);
        chk("hold_valid0", {31'd0, v0}, 32'd1);
        chk("restart_end_pc1", p1, 32'h300);
        chk("restart_end_valid1", {31'd0, v1}, 32'd1);
        step(0, 0, 0, 0, 0, 1);
        step(0, 1, 0, 0, 0, 1);
        #1 chk("accepted_pc0", p0, 32'h304);
        chk("stall_valid0", {31'd0, v0}, 32'd0);

        // Redirect while stalled wins.
        step(0, 1, 1, 1, 32'h0000_0200, 1);
        #1 chk("stall_redir_flush0", {31'd0, f0}, 32'd1);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        #1 chk("stall_redir_pc0", p0, 32'h200);

        // Statistics: boot resolution ignored, then 5 resolutions with 3 taken.
        step(1, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 1);
        step(0, 0, 1, 1, 32'h80, 1);
        step(0, 0, 1, 0, 32'h0,  1);
        step(0, 0, 1, 1, 32'h40, 1);
        step(0, 0, 1, 0, 32'h0,  1);
        step(0, 0, 1, 1, 32'h44, 1);
        step(0, 0, 1, 1, 32'h48, 1);
        step(0, 0, 0, 0, 0, 1);
`ifdef BRANCH_STATS_EN
        exp_tot = 32'd5; exp_tak = 32'd3;
`else
        exp_tot = 32'd0; exp_tak = 32'd0;
`endif
        #1 chk("stats_total0", tt0, exp_tot);
        chk("stats_taken0", tk0, exp_tak);
        chk("stats_total1", tt1, exp_tot);
        chk("stats_taken1", tk1, exp_tak);

        // Reset in the middle of dut1's bubble.
        step(0, 0, 1, 1, 32'h500, 1);
        step(1, 0, 0, 0, 0, 1);
        #1 chk("midrst_total1", tt1, 32'd0);
        chk("midrst_flush1", {31'd0, f1}, 32'd0);
        chk("midrst_pc1", p1, 32'hFFFF_FFFC);
        step(0, 0, 1, 1, 32'h600, 1);
        #1 chk("midrst_boot_flush1", {31'd0, f1}, 32'd0);
        chk("midrst_boot_valid1", {31'd0, v1}, 32'd0);

        // Randomized phase, checked only through the scoreboard.
        for (int n = 0; n < 3000; n++) begin
            step(($urandom_range(0, 63) == 0),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 2) == 0),
                 $urandom_range(0, 1) == 1,
                 $urandom,
                 ($urandom_range(0, 3) != 0));
        end
        step(0, 0, 0, 0, 0, 1);

        @(posedge clk);
        @(posedge clk);
        chk("sb0_drained", q0.size(), 32'd0);
        chk("sb1_drained", q1.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_pc_ctrl.md
Name: fetch_pc_ctrl

Overview:
Program-counter and fetch-redirect controller for the 3-stage pipeline. It consumes the branch/jump resolution (taken flag plus target) from the execute stage and issues fetch addresses to instruction memory over a valid/ready handshake. On a taken branch it squashes wrong-path instructions with a flush pulse and an optional bubble window.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
FLUSH_CYCLES, 1, extra bubble cycles after a redirect (0..15); 0 means fetch resumes on the cycle after the redirect.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  asynchronous, active-high reset.
stall_i  input  1  hazard stall from decode/execute; holds PC and suppresses fetch.
br_valid_i  input  1  execute stage presents a resolved branch/jump this cycle.
branch_taken  input  1  resolution result; meaningful only when br_valid_i=1.
br_target  input  32  redirect target address.
if_ready_i  input  1  instruction memory accepts the request.
if_valid_o  output  1  fetch request valid.
pc_o  output  32  fetch address.
flush_o  output  1  kill the instruction held in the fetch/decode stage register.
br_taken_cnt_o  output  32  taken-branch count (see Optional Feature).
br_total_cnt_o  output  32  resolved-branch count (see Optional Feature).

Behaviour:
- Reset (async, rst=1): pc_o=RESET_PC, state=BOOT, if_valid_o=0, flush_o=0, bubble counter=0, both count outputs=0.
- States: BOOT, RUN, FLUSH.
- BOOT: lasts exactly one cycle after rst deasserts. if_valid_o=0. Redirects are ignored. Next state is RUN.
- RUN, request: if_valid_o = !stall_i.
- RUN, fire: fire = if_valid_o & if_ready_i. On fire, pc <= pc+4, truncated to 32 bits so 32'hFFFF_FFFC wraps to 0. Without fire, pc holds.
- Redirect condition: redirect = br_valid_i & branch_taken, evaluated in RUN or FLUSH.
- Redirect response:
  - flush_o=1 combinationally in the same cycle.
  - At the next edge, pc <= {br_target[31:2],2'b00}; the low two bits are always forced to zero.
  - Redirect has priority over fire and stall_i; a fire in the redirect cycle does not increment the PC.
  - If FLUSH_CYCLES=0, the next state is RUN. Otherwise the next state is FLUSH with the bubble counter = FLUSH_CYCLES.
- FLUSH: if_valid_o=0, flush_o=1. The bubble counter decrements each cycle; at 1 the state moves to RUN. A redirect in FLUSH reloads the new target and restarts the counter at FLUSH_CYCLES.
- br_valid_i=1 with branch_taken=0: no PC or state effect.
- pc_o holds its value between fires, except on a redirect. if_valid_o may drop because of stall_i or a flush; the memory must not assume a request persists.
- stall_i during FLUSH: no effect on the bubble countdown.
- Reset mid-operation: all state returns to reset values immediately, regardless of state or the bubble counter.

Optional Feature:
Macro BRANCH_STATS_EN.
- Defined: two 32-bit wrapping counters, reset to 0.
  - br_total_cnt_o increments on every cycle with br_valid_i=1 in RUN or FLUSH.
  - br_taken_cnt_o increments additionally when branch_taken=1.
  - BOOT-cycle resolutions are not counted.
- Not defined: both ports are tied to 32'h0 and no counter flops are built. The port list is identical in both builds.

Test Plan:
- Reset then if_ready_i=1, no branches -> BOOT for 1 cycle with if_valid_o=0; pc_o sequence 0x0, 0x4, 0x8, 0xC on successive fires.
- In RUN at pc 0x10, br_valid_i=1, branch_taken=1, br_target=0x103 (FLUSH_CYCLES=1) -> flush_o=1 that cycle and the next; if_valid_o=0 for the bubble; pc_o=0x100 with if_valid_o=1 two cycles after the redirect.
- if_ready_i=0 for 3 cycles at pc 0x20, then 1 -> pc_o stays 0x20 and if_valid_o stays 1 throughout; pc_o becomes 0x24 after the accepted fire.
- stall_i=1 for 2 cycles, plus a simultaneous redirect to 0x200 while stalled -> redirect wins; pc_o=0x200 and flush_o pulses.
- Second redirect to 0x300 during FLUSH (FLUSH_CYCLES=3), then RESET_PC=32'hFFFF_FFFC start -> the 0x300 redirect restarts the 3-cycle bubble; the RESET_PC start wraps pc_o to 0x0 after the first fire.
- BRANCH_STATS_EN defined: 5 resolutions (3 taken) -> br_total_cnt_o=5, br_taken_cnt_o=3. Not defined: same stimulus -> both outputs 0. Also assert rst mid-FLUSH -> counters 0, state BOOT.
